// File: rtl/sm2_pkg.sv
// sm2_pkg: shared widths, curve moduli and arbiter FSM states for mod_inv_arb
package sm2_pkg;
  localparam int WIDTH = 256;
  localparam logic [255:0] SM2_P = 256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff;
  localparam logic [255:0] NIST_P = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
endpackage

// File: rtl/mod_inv_arb_if.sv
// mod_inv_arb_if: requester, response and engine signals of the shared inverter front end
interface mod_inv_arb_if #(parameter int WIDTH = 256);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_p0;
  logic [WIDTH-1:0] req_p1;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_id;
  logic rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic inv_start;
  logic [WIDTH-1:0] inv_in;
  logic [WIDTH-1:0] inv_p;
  logic [WIDTH-1:0] inv_res;
  logic inv_finish;
  modport master (
    output req_valid, req_a0, req_a1, req_p0, req_p1, rsp_ready, inv_res, inv_finish,
    input req_ready, rsp_valid, rsp_id, rsp_err, rsp_data, inv_start, inv_in, inv_p
  );
  modport slave (
    input req_valid, req_a0, req_a1, req_p0, req_p1, rsp_ready, inv_res, inv_finish,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_data, inv_start, inv_in, inv_p
  );
endinterface

// File: rtl/mod_inv_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant, ptr names the requester with first priority
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  // favour ptr, fall back to the other requester, else no grant
  always_comb grant = valid[ptr] ? (ptr ? 2'b10 : 2'b01) : valid[~ptr] ? (ptr ? 2'b01 : 2'b10) : 2'b00;
endmodule

// File: rtl/mod_inv_arb.sv
// mod_inv_arb: round-robin front end sharing one mod_inv engine between two requesters
module mod_inv_arb #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst_n,
  mod_inv_arb_if.slave bus
);
  import sm2_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_d;
  logic rr_ptr, rr_d, id_q, id_d, err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d, p_q, p_d, data_q, data_d, a_sel, p_sel;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] grant;
  rr_arb2 u_arb (.valid(bus.req_valid), .ptr(rr_ptr), .grant(grant));
  assign a_sel = grant[1] ? bus.req_a1 : bus.req_a0;
  assign p_sel = grant[1] ? bus.req_p1 : bus.req_p0;
  assign bus.req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign bus.inv_start = state == START;
  assign bus.inv_in    = a_q;
  assign bus.inv_p     = p_q;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  // next state: accept/bypass in IDLE, pulse engine, wait for a fresh finish or timeout, hold response
  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    id_d    = id_q;
    a_d     = a_q;
    p_d     = p_q;
    cnt_d   = cnt;
    data_d  = data_q;
    err_d   = err_q;
    case (state)
      IDLE: if (|grant) begin
        id_d    = grant[1];
        rr_d    = ~grant[1];
        a_d     = a_sel;
        p_d     = p_sel;
        data_d  = '0;
        err_d   = a_sel == '0;
        state_d = a_sel == '0 ? RESP : START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + CW'(1);
        if (cnt != '0 && bus.inv_finish) begin
          data_d  = bus.inv_res;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  // state and operand registers, cleared asynchronously so a reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      id_q   <= 1'b0;
      a_q    <= '0;
      p_q    <= '0;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_d;
      id_q   <= id_d;
      a_q    <= a_d;
      p_q    <= p_d;
      cnt    <= cnt_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_mod_inv_arb.sv
// tb_mod_inv_arb: randomized check of arbitration, inversion results, bypass, timeout and reset
module tb_mod_inv_arb;
  import sm2_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int starts = 0;
  int eng_mode = 0;
  int eng_lat = 1;
  int eng_cnt = 0;
  logic fin_r = 1'b0;
  logic [255:0] res_r = '0;
  logic [255:0] pend = '0;
  logic [255:0] tmp;
  logic rr_m = 1'b0;
  mod_inv_arb_if #(.WIDTH(WIDTH)) bus ();
  mod_inv_arb #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y, input logic [255:0] p);
    logic [511:0] t;
    t = {256'b0, x} * {256'b0, y};
    return 256'(t % {256'b0, p});
  endfunction
  function automatic logic [255:0] modinv(input logic [255:0] x, input logic [255:0] p);
    logic [255:0] e, r, b;
    e = p - 256'd2;
    r = 256'd1;
    b = 256'(({256'b0, x}) % {256'b0, p});
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, b, p);
      b = mulmod(b, b, p);
    end
    return r;
  endfunction
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge clk) if (bus.inv_start) starts++;
  assign bus.inv_finish = eng_mode == 1 ? 1'b1 : eng_mode == 2 ? 1'b0 : fin_r;
  assign bus.inv_res = res_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_r <= 1'b0;
      eng_cnt <= 0;
      res_r <= '0;
    end else if (bus.inv_start) begin
      tmp = modinv(bus.inv_in, bus.inv_p);
      pend <= tmp;
      eng_cnt <= eng_lat + 2;
      if (eng_mode == 1) res_r <= tmp;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == eng_lat + 2) fin_r <= 1'b0;
      if (eng_cnt == 1) begin
        fin_r <= 1'b1;
        res_r <= pend;
      end
    end
  end
  task automatic xact(input string tag, input logic [1:0] v, input logic [255:0] a0, input logic [255:0] p0,
                      input logic [255:0] a1, input logic [255:0] p1, input int stall, input int exp_lat,
                      input logic exact_en, input logic [255:0] exact);
    logic win, i0, e0, stable, busy_bad, exp_err;
    logic [255:0] a, p, d0;
    int cyc, s0;
    win = v[rr_m] ? rr_m : ~rr_m;
    rr_m = ~win;
    a = win ? a1 : a0;
    p = win ? p1 : p0;
    exp_err = (a == '0) || (eng_mode == 2);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_a0 = a0;
    bus.req_p0 = p0;
    bus.req_a1 = a1;
    bus.req_p1 = p1;
    bus.rsp_ready = 1'b0;
    s0 = starts;
    #1;
    cyc = 0;
    while (bus.req_ready == 2'b00 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_rdy"}, 256'(bus.req_ready), win ? 256'd2 : 256'd1);
    @(negedge clk);
    cyc = 1;
    chk({tag, "_start"}, 256'(bus.inv_start), 256'(a != '0));
    busy_bad = 1'b0;
    while (!bus.rsp_valid && cyc < 40) begin
      if (bus.req_ready != 2'b00) busy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_rvld"}, 256'(bus.rsp_valid), 256'd1);
    if (exp_lat > 0) chk({tag, "_lat"}, 256'(cyc), 256'(exp_lat));
    i0 = bus.rsp_id;
    d0 = bus.rsp_data;
    e0 = bus.rsp_err;
    stable = 1'b1;
    if (bus.req_ready != 2'b00) busy_bad = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== i0 || bus.rsp_data !== d0 || bus.rsp_err !== e0) stable = 1'b0;
      if (bus.req_ready != 2'b00) busy_bad = 1'b1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b00;
    chk({tag, "_busy"}, 256'(busy_bad), 256'd0);
    chk({tag, "_stable"}, 256'(stable), 256'd1);
    chk({tag, "_id"}, 256'(i0), 256'(win));
    chk({tag, "_err"}, 256'(e0), 256'(exp_err));
    if (exp_err) chk({tag, "_data0"}, d0, '0);
    else chk({tag, "_inv"}, mulmod(a, d0, p), 256'd1);
    if (exact_en) chk({tag, "_exact"}, d0, exact);
    chk({tag, "_nstart"}, 256'(starts - s0), 256'(a != '0));
  endtask
  initial begin
    logic [255:0] x0, x1;
    logic [1:0] v;
    int gone;
    bus.req_valid = 2'b00;
    bus.req_a0 = '0;
    bus.req_a1 = '0;
    bus.req_p0 = '0;
    bus.req_p1 = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 256'({bus.inv_start, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err}), '0);
    chk("rst_bus", bus.rsp_data | bus.inv_in | bus.inv_p, '0);
    rst_n = 1'b1;
    eng_lat = 2;
    xact("sm2", 2'b01, 256'hc239507105c683242a81052ff641ed69009a084ad5cc937db21646cd34a0ced5, SM2_P, '0, '0, 1, -1, 1'b0, '0);
    xact("nist", 2'b10, '0, '0, 256'h69fe7d23f8dd5a7c958acb41a62f15692668b35d2d4ed54c0a8464e387439478, NIST_P, 2, -1,
         1'b1, 256'he05215cbc412474d522e1ef9d676888593b586030bce722aa456da5e204fd057);
    for (int i = 0; i < 4; i++) begin
      eng_lat = $urandom_range(1, 6);
      xact($sformatf("both%0d", i), 2'b11, rnd256(), SM2_P, rnd256(), NIST_P, 0, -1, 1'b0, '0);
    end
    xact("zero", 2'b10, rnd256(), SM2_P, '0, NIST_P, 1, 1, 1'b0, '0);
    eng_mode = 1;
    xact("fin_hi", 2'b01, rnd256(), NIST_P, '0, '0, 0, 4, 1'b0, '0);
    eng_mode = 2;
    xact("fin_lo", 2'b10, '0, '0, rnd256(), SM2_P, 0, 18, 1'b0, '0);
    eng_mode = 0;
    for (int i = 0; i < 20; i++) begin
      v = 2'($urandom_range(1, 3));
      x0 = ($urandom_range(0, 7) == 0) ? '0 : rnd256();
      x1 = ($urandom_range(0, 7) == 0) ? '0 : rnd256();
      eng_lat = $urandom_range(1, 6);
      xact($sformatf("rnd%0d", i), v, x0, $urandom_range(0, 1) ? SM2_P : NIST_P, x1,
           $urandom_range(0, 1) ? SM2_P : NIST_P, $urandom_range(0, 3), -1, 1'b0, '0);
    end
    xact("stall", 2'b01, rnd256(), SM2_P, '0, '0, 10, -1, 1'b0, '0);
    eng_mode = 2;
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_a0 = rnd256();
    bus.req_p0 = SM2_P;
    #1;
    chk("abort_rdy", 256'(bus.req_ready), 256'd1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("mid_rst_ctl", 256'({bus.inv_start, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err}), '0);
    chk("mid_rst_bus", bus.rsp_data | bus.inv_in | bus.inv_p, '0);
    bus.req_valid = 2'b00;
    rr_m = 1'b0;
    eng_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    gone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.inv_start) gone++;
    end
    chk("abort_quiet", 256'(gone), '0);
    bus.req_valid = 2'b11;
    #1;
    chk("rr_after_rst", 256'(bus.req_ready), 256'd1);
    bus.req_valid = 2'b00;
    xact("post_rst", 2'b11, rnd256(), NIST_P, rnd256(), SM2_P, 0, -1, 1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_inv_arb.md
MOD_INV_ARB -- requirements
Module: mod_inv_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 256, meaning operand/modulus width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 4096, meaning the maximum number of cycles to wait for engine finish.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports req_valid and req_ready, input and output, 2 bits each: per-requester request handshake (bit 0 = requester 0).
REQ-006 The block SHALL have ports req_a0 and req_a1, input, WIDTH bits each: operand to invert for each requester.
REQ-007 The block SHALL have ports req_p0 and req_p1, input, WIDTH bits each: modulus for each requester.
REQ-008 The block SHALL have ports rsp_valid and rsp_ready, output and input, 1 bit each: response handshake.
REQ-009 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the response.
REQ-010 The block SHALL have port rsp_data, output, WIDTH bits: a^-1 mod p.
REQ-011 The block SHALL have port rsp_err, output, 1 bit: set on zero-operand bypass or timeout.
REQ-012 The block SHALL have ports inv_start, inv_in and inv_p, output, 1/WIDTH/WIDTH bits: drive the shared mod_inv engine.
REQ-013 The block SHALL have ports inv_res and inv_finish, input, WIDTH/1 bits: results from the shared mod_inv engine.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT and RESP.
REQ-015 In IDLE, req_ready SHALL be one-hot on the granted requester, combinationally from req_valid and the round-robin pointer rr_ptr; it SHALL be 0 when no request is valid.
REQ-016 Arbitration SHALL use rr_ptr as the first-priority index; when both requesters are valid, rr_ptr wins.
REQ-017 On accept (req_valid & req_ready), the block SHALL latch a, p and id and set rr_ptr to the index other than id.
REQ-018 On accept with a == 0, the block SHALL go directly to RESP with rsp_data = 0 and rsp_err = 1, without pulsing the engine.
REQ-019 On accept with a != 0, the block SHALL go to START.
REQ-020 In START, inv_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-021 inv_in and inv_p SHALL be held at the latched values from START until leaving WAIT.
REQ-022 inv_finish SHALL be ignored in START and on the first WAIT cycle, because finish may still be high from the previous operation.
REQ-023 From the second WAIT cycle, inv_finish = 1 SHALL capture inv_res into rsp_data with rsp_err = 0, and the FSM SHALL go to RESP.
REQ-024 A WAIT counter SHALL count cycles; on reaching TIMEOUT, the block SHALL set rsp_data = 0 and rsp_err = 1, then go to RESP.
REQ-025 Latency: accept at cycle 0, inv_start at cycle 1, rsp_valid on the cycle after the qualifying finish.
REQ-026 In RESP, rsp_valid SHALL be 1, with rsp_id, rsp_data and rsp_err stable until rsp_ready.
REQ-027 On rsp_valid & rsp_ready, the FSM SHALL return to IDLE.
REQ-028 No request SHALL be accepted in the same cycle as the response handshake.
REQ-029 req_ready SHALL be 0 in every state except IDLE.
REQ-030 A requester dropping req_valid before grant SHALL have no effect.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously enter IDLE with rr_ptr = 0 and the WAIT counter = 0.
REQ-032 On rst_n low, all outputs SHALL be 0: inv_start, req_ready, rsp_valid, rsp_id, rsp_err, rsp_data, inv_in and inv_p.
REQ-033 Reset mid-operation SHALL abort the operation with no response; the engine is reset by the same rst_n.

Structure
REQ-034 Package sm2_pkg SHALL hold WIDTH, SM2_P (fffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff), NIST_P (ffffffff00000001000000000000000000000000ffffffffffffffffffffffff) and the FSM state type.
REQ-035 The block SHALL contain one sub-module, rr_arb2, which is the 2-way round-robin grant logic.
REQ-036 mod_inv SHALL be instantiated outside this block.

Verification
REQ-037 Requester 0 sends a = c239507105c683242a81052ff641ed69009a084ad5cc937db21646cd34a0ced5 with p = SM2_P -> rsp_id = 0, rsp_err = 0, (a*rsp_data) mod p == 1.
REQ-038 Requester 1 sends a = 69fe7d23f8dd5a7c958acb41a62f15692668b35d2d4ed54c0a8464e387439478 with p = NIST_P -> rsp_data = e05215cbc412474d522e1ef9d676888593b586030bce722aa456da5e204fd057, rsp_id = 1.
REQ-039 Both requesters valid continuously for 4 operations after reset -> grants 0,1,0,1, and each response carries the matching id.
REQ-040 a = 0 from requester 1 -> rsp_valid at cycle 1, rsp_err = 1, rsp_data = 0, and inv_start never asserted.
REQ-041 Engine model with finish stuck high and TIMEOUT = 16 -> first op completes at WAIT cycle 2; with finish stuck low -> rsp_err = 1 after 16 WAIT cycles.
REQ-042 rsp_ready held low for 10 cycles, then rst_n pulsed low in WAIT on the next op -> response held stable while stalled; after reset, all outputs are 0, IDLE, and rr_ptr = 0.
